// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// Takes a WIDTH-bit operand pair, walks it LSB-first through a single
// full-adder cell (one bit per clock, registered carry) and returns a
// WIDTH+1-bit sum. The low APPROX_LSBS positions may use an approximate
// cell for the transaction when approx_en was high at accept time.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid and ready are both high. Once out_valid is raised it stays
// high, with sum stable, until that transfer. in_ready and out_valid are
// decoded from registered state only, so neither depends combinationally
// on in_valid or out_ready.

module serial_add_ctrl #(
  parameter int WIDTH       = 8,
  parameter int APPROX_LSBS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  // Bit counter only needs to reach WIDTH-1; RUN is left at that count.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             approx_q, approx_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   sum_q, sum_d;

  // Adder cell signals for the current bit position.
  logic cell_a;
  logic cell_b;
  logic use_approx;
  logic exact_s;
  logic exact_c;
  logic apx_s;
  logic apx_c;
  logic cell_s;
  logic cell_c;

  // Full-adder cell: exact and approximate variants, selected per bit.
  // The approximate cell only differs on rows a=1,b=1 (cin 0 or 1).
  always_comb begin
    cell_a     = a_q[0];
    cell_b     = b_q[0];
    use_approx = approx_q && (int'(cnt_q) < APPROX_LSBS);
    exact_s    = cell_a ^ cell_b ^ carry_q;
    exact_c    = (cell_a & cell_b) | (cell_a & carry_q) | (cell_b & carry_q);
    apx_c      = carry_q & (cell_a | cell_b);
    apx_s      = (cell_a | cell_b | carry_q) & ~apx_c;
    cell_s     = use_approx ? apx_s : exact_s;
    cell_c     = use_approx ? apx_c : exact_c;
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          approx_d = approx_en;
          carry_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        // Drop this cycle's sum bit into its final position.
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[i] = cell_s;
          end
        end
        carry_d = cell_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: the cell's carry-out is the sum MSB. The counter
          // is left at its last value rather than wrapped.
          sum_d[WIDTH] = cell_c;
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous active-low reset wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
    end
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    sum       = sum_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8, APPROX_LSBS=4): directed vector
// table, hand-written multi-cycle sequences, and random transactions
// scored against an arithmetic reference model.

module tb_serial_add_ctrl;

  localparam int WIDTH       = 8;
  localparam int APPROX_LSBS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             approx_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0] exp_q[$];

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic             vap;
    int               hold;
    logic [WIDTH:0]   exp_sum;
  } vec_t;

  vec_t vecs[10];

  serial_add_ctrl #(
    .WIDTH      (WIDTH),
    .APPROX_LSBS(APPROX_LSBS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .approx_en(approx_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .busy     (busy)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare helpers
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [WIDTH:0] act,
                           input logic [WIDTH:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%03h expected 0x%03h", name, act, exp);
    end
  endtask

  // Reference model: approximate rule on the low bits when enabled,
  // then ordinary integer addition of the remaining upper bits.
  function automatic logic [WIDTH:0] model_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic ap);
    int lo;
    int c;
    int res;
    lo  = ap ? APPROX_LSBS : 0;
    c   = 0;
    res = 0;
    for (int i = 0; i < lo; i++) begin
      int xi;
      int yi;
      int co;
      int si;
      xi  = x[i] ? 1 : 0;
      yi  = y[i] ? 1 : 0;
      co  = (c == 1 && (xi + yi) > 0) ? 1 : 0;
      si  = ((xi + yi + c) > 0 && co == 0) ? 1 : 0;
      res = res + (si << i);
      c   = co;
    end
    res = res + (((int'(x) >> lo) + (int'(y) >> lo) + c) << lo);
    return res[WIDTH:0];
  endfunction

  // Driver: one full transaction, checked cycle by cycle. hold = number of
  // extra DONE cycles with out_ready low. isolate = keep in_valid high and
  // scramble operands during RUN.
  task automatic do_txn(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb_v, input logic tap,
                        input int hold, input bit isolate,
                        input logic [WIDTH:0] expect_sum);
    logic [WIDTH:0] exp_v;
    exp_q.push_back(expect_sum);
    a         = ta;
    b         = tb_v;
    approx_en = tap;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check_bit({tag, ".in_ready_before"}, in_ready, 1'b1);
    tick();  // accept edge
    if (isolate) begin
      a         = '0;
      b         = '0;
      approx_en = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < WIDTH; k++) begin
      check_bit({tag, ".run_out_valid"}, out_valid, 1'b0);
      check_bit({tag, ".run_in_ready"}, in_ready, 1'b0);
      check_bit({tag, ".run_busy"}, busy, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check_bit({tag, ".out_valid_rise"}, out_valid, 1'b1);
    exp_v = exp_q.pop_front();
    check_val({tag, ".sum"}, sum, exp_v);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_bit({tag, ".hold_out_valid"}, out_valid, 1'b1);
      check_val({tag, ".hold_sum"}, sum, exp_v);
      check_bit({tag, ".hold_in_ready"}, in_ready, 1'b0);
      check_bit({tag, ".hold_busy"}, busy, 1'b1);
    end
    out_ready = 1'b1;
    tick();  // output handshake edge
    check_bit({tag, ".out_valid_fall"}, out_valid, 1'b0);
    check_bit({tag, ".in_ready_after"}, in_ready, 1'b1);
    check_bit({tag, ".busy_after"}, busy, 1'b0);
  endtask

  initial begin
    // Directed vector table (expected sums computed by hand)
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 0, 9'h096};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 0, 9'h100};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 0, 9'h0FF};
    vecs[3] = '{8'h03, 8'h03, 1'b1, 0, 9'h003};
    vecs[4] = '{8'h03, 8'h03, 1'b0, 0, 9'h006};
    vecs[5] = '{8'h5A, 8'h3C, 1'b0, 5, 9'h096};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 0, 9'h1FE};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 2, 9'h1EF};
    vecs[8] = '{8'h0F, 8'h01, 1'b1, 0, 9'h00F};
    vecs[9] = '{8'h00, 8'h00, 1'b1, 1, 9'h000};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    approx_en = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    check_bit("reset.in_ready", in_ready, 1'b1);
    check_bit("reset.out_valid", out_valid, 1'b0);
    check_bit("reset.busy", busy, 1'b0);
    check_val("reset.sum", sum, 9'h000);
    tick();
    check_bit("idle.in_ready", in_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vap,
             vecs[i].hold, 1'b0, vecs[i].exp_sum);
    end

    // Input isolation: operands scrambled and in_valid held during RUN
    do_txn("isolate", 8'h5A, 8'h3C, 1'b0, 0, 1'b1, 9'h096);
    tick();
    check_bit("isolate.no_second_accept", busy, 1'b0);

    // Reset in the 3rd RUN cycle aborts the transaction
    a         = 8'h5A;
    b         = 8'h3C;
    approx_en = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();  // accept
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_bit("abort.out_valid", out_valid, 1'b0);
    check_val("abort.sum", sum, 9'h000);
    check_bit("abort.in_ready", in_ready, 1'b1);
    check_bit("abort.busy", busy, 1'b0);
    for (int k = 0; k < WIDTH + 2; k++) begin
      tick();
      check_bit("abort.no_pulse", out_valid, 1'b0);
    end
    do_txn("after_abort", 8'h80, 8'h80, 1'b0, 0, 1'b0, 9'h100);

    // Random transactions against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rap;
      int               rh;
      ra  = WIDTH'($urandom_range(0, 255));
      rb  = WIDTH'($urandom_range(0, 255));
      rap = 1'($urandom_range(0, 1));
      rh  = $urandom_range(0, 3);
      do_txn($sformatf("rand%0d", n), ra, rb, rap, rh, 1'b0,
             model_add(ra, rb, rap));
      if ($urandom_range(0, 1) == 1) begin
        tick();
      end
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
